frame_loader: RTL

- Parametrised synthesizable successor to the simulation memory loader.
- Accepts a valid/ready sample stream (ADC front end or bench source) and writes FRAME_LEN samples into the sample RAM starting at BASE_ADDR.
- Optional decimation; single-shot or continuous ring-buffer mode.
- Signals frame completion to the pitch-detection stage.

---
 rtl/frame_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/frame_loader.sv
// Streams valid/ready samples into the sample RAM, one frame at a time,
// with optional decimation and single-shot or ring-buffer operation.
module frame_loader #(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 11,
  parameter int FRAME_LEN = 1024,
  parameter int BASE_ADDR = 0,
  parameter int DECIM     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              write_enable,
  output logic              busy,
  output logic              data_loaded,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  if (BASE_ADDR + FRAME_LEN > (1 << ADDR_W)) begin : g_range_chk
    $error("frame_loader: frame does not fit in RAM");
  end
  if (DECIM < 1 || DECIM > 256) begin : g_decim_chk
    $error("frame_loader: DECIM out of range");
  end

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [CW-1:0]     decim_cnt;
  logic              cont_q;

  logic accept;
  logic keep;
  logic last;
  logic start_ok;
  logic abort_ok;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD);
  assign accept   = in_valid && in_ready;
  assign keep     = accept && (decim_cnt == C_LAST);
  assign last     = keep && (idx == I_LAST);
  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign abort_ok = abort && (state == S_LOAD);

  // Output register: the single stage of latency between accept and RAM write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      addr         <= '0;
      data_out     <= '0;
    end else begin
      write_enable <= keep;
      frame_done   <= last;
      if (keep) begin
        addr     <= BASE + idx;
        data_out <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      decim_cnt   <= '0;
      cont_q      <= 1'b0;
      data_loaded <= 1'b0;
    end else if (start_ok) begin
      state       <= S_LOAD;
      idx         <= '0;
      decim_cnt   <= '0;
      cont_q      <= continuous;
      data_loaded <= 1'b0;
    end else if (abort_ok) begin
      state     <= S_IDLE;
      idx       <= '0;
      decim_cnt <= '0;
      // A ring buffer keeps its last complete frame valid across abort.
      if (!cont_q) begin
        data_loaded <= 1'b0;
      end else if (last) begin
        data_loaded <= 1'b1;
      end
    end else if (accept) begin
      if (keep) begin
        decim_cnt <= '0;
        if (last) begin
          idx         <= '0;
          data_loaded <= 1'b1;
          if (!cont_q) begin
            state <= S_DONE;
          end
        end else begin
          idx <= idx + ADDR_W'(1);
        end
      end else begin
        decim_cnt <= decim_cnt + CW'(1);
      end
    end
  end

endmodule
